// File: rtl/axiss_to_spi_dac.sv
// ============================================================================
//  Module   : axiss_to_spi_dac
//  Purpose  : AXI-Stream sample FIFO feeding a fixed-rate, write-only 16-bit
//             SPI DAC frame (SSN/SCK/MOSI, MSB first, SCK idles high).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module axiss_to_spi_dac #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SPI_SCK_DIV = 200,
    parameter int SAMPLE_DIV  = 6250
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESETN,
    input  logic                  S_AXIS_TVALID,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    output logic                  SPI_SSN,
    output logic                  SPI_SCK,
    output logic                  SPI_MOSI,
    output logic                  UNDERRUN
);

    localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
    localparam int c_lvl_w  = c_ptr_w + 1;
    localparam int c_half   = SPI_SCK_DIV / 2;
    localparam int c_half_w = $clog2(c_half);
    localparam int c_cnt_w  = $clog2(SAMPLE_DIV);
    localparam int c_tog_w  = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(SAMPLE_DIV - 1);
    localparam logic [c_half_w-1:0] c_half_last = c_half_w'(c_half - 1);
    localparam logic [c_tog_w-1:0]  c_tog_last  = c_tog_w'(2 * DATA_WIDTH);
    localparam logic [c_lvl_w-1:0]  c_lvl_full  = c_lvl_w'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [c_cnt_w-1:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  mem_d [FIFO_DEPTH];
    logic [c_ptr_w-1:0]     wr_q, wr_d;
    logic [c_ptr_w-1:0]     rd_q, rd_d;
    logic [c_lvl_w-1:0]     lvl_q, lvl_d;
    logic                   tready_q, tready_d;
    logic [DATA_WIDTH-1:0]  last_q, last_d;
    logic [DATA_WIDTH-2:0]  shift_q, shift_d;
    logic [c_half_w-1:0]    hc_q, hc_d;
    logic [c_tog_w-1:0]     tg_q, tg_d;
    logic                   ssn_q, ssn_d;
    logic                   sck_q, sck_d;
    logic                   mosi_q, mosi_d;
    logic                   urun_q, urun_d;

    logic                   w_tick;
    logic                   w_push;
    logic                   w_pop;
    logic [DATA_WIDTH-1:0]  w_frame_word;

    // TLAST carries no meaning for a continuous audio stream.
    logic unused_tlast;
    assign unused_tlast = S_AXIS_TLAST;

    always_comb begin
        w_tick       = (cnt_q == c_cnt_last);
        w_push       = S_AXIS_TVALID && tready_q;
        w_pop        = w_tick && (lvl_q != '0);
        w_frame_word = w_pop ? mem_q[rd_q] : last_q;

        state_d  = state_q;
        mem_d    = mem_q;
        wr_d     = wr_q;
        rd_d     = rd_q;
        last_d   = last_q;
        shift_d  = shift_q;
        hc_d     = hc_q;
        tg_d     = tg_q;
        ssn_d    = ssn_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        cnt_d    = w_tick ? '0 : cnt_q + c_cnt_w'(1);
        urun_d   = w_tick && (lvl_q == '0);

        if (w_push) begin
            mem_d[wr_q] = S_AXIS_TDATA;
            wr_d        = wr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            rd_d   = rd_q + c_ptr_w'(1);
            last_d = mem_q[rd_q];
        end

        case ({w_push, w_pop})
            2'b10:   lvl_d = lvl_q + c_lvl_w'(1);
            2'b01:   lvl_d = lvl_q - c_lvl_w'(1);
            default: lvl_d = lvl_q;
        endcase
        tready_d = (lvl_d != c_lvl_full);

        case (state_q)
            ST_IDLE: begin
                if (w_tick) begin
                    state_d = ST_SHIFT;
                    ssn_d   = 1'b0;
                    sck_d   = 1'b1;
                    mosi_d  = w_frame_word[DATA_WIDTH-1];
                    shift_d = w_frame_word[DATA_WIDTH-2:0];
                    hc_d    = '0;
                    tg_d    = '0;
                end
            end
            ST_SHIFT: begin
                if (hc_q == c_half_last) begin
                    hc_d = '0;
                    tg_d = tg_q + c_tog_w'(1);
                    // Odd toggle count is a fall; the final rise closes the frame.
                    if (tg_d == c_tog_last) begin
                        state_d = ST_IDLE;
                        ssn_d   = 1'b1;
                        sck_d   = 1'b1;
                        mosi_d  = 1'b0;
                    end else if (tg_d[0]) begin
                        sck_d = 1'b0;
                    end else begin
                        sck_d   = 1'b1;
                        mosi_d  = shift_q[DATA_WIDTH-2];
                        shift_d = {shift_q[DATA_WIDTH-3:0], 1'b0};
                    end
                end else begin
                    hc_d = hc_q + c_half_w'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mem_q    <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            lvl_q    <= '0;
            tready_q <= 1'b0;
            last_q   <= '0;
            shift_q  <= '0;
            hc_q     <= '0;
            tg_q     <= '0;
            ssn_q    <= 1'b1;
            sck_q    <= 1'b1;
            mosi_q   <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            lvl_q    <= lvl_d;
            tready_q <= tready_d;
            last_q   <= last_d;
            shift_q  <= shift_d;
            hc_q     <= hc_d;
            tg_q     <= tg_d;
            ssn_q    <= ssn_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            urun_q   <= urun_d;
        end
    end

    assign S_AXIS_TREADY = tready_q;
    assign SPI_SSN       = ssn_q;
    assign SPI_SCK       = sck_q;
    assign SPI_MOSI      = mosi_q;
    assign UNDERRUN      = urun_q;

endmodule

`default_nettype wire

// File: tb/tb_axiss_to_spi_dac.sv
// ============================================================================
//  Module   : tb_axiss_to_spi_dac
//  Purpose  : Scoreboard bench: sample-queue reference model predicts each SPI
//             frame, an independent SPI decoder pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axiss_to_spi_dac;

    localparam int DW     = 16;
    localparam int DEPTH  = 8;
    localparam int SCKDIV = 4;
    localparam int SDIV   = 80;
    localparam int H      = SCKDIV / 2;

    logic          clk    = 1'b0;
    logic          rstn   = 1'b0;
    logic          tvalid = 1'b0;
    logic          tlast  = 1'b0;
    logic [DW-1:0] tdata  = '0;
    wire           tready, ssn, sck, mosi, urun;

    axiss_to_spi_dac #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SPI_SCK_DIV(SCKDIV),
        .SAMPLE_DIV (SDIV)
    ) dut (
        .AXIS_ACLK    (clk),
        .AXIS_ARESETN (rstn),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TDATA (tdata),
        .S_AXIS_TLAST (tlast),
        .S_AXIS_TREADY(tready),
        .SPI_SSN      (ssn),
        .SPI_SCK      (sck),
        .SPI_MOSI     (mosi),
        .UNDERRUN     (urun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] word;
        logic          urun;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference model: sample queue, last sample, sample-period counter.
    logic [DW-1:0] m_fifo[$];
    logic [DW-1:0] m_last   = '0;
    int            m_cnt    = 0;
    logic          m_tready = 1'b0;
    logic          m_in_rst = 1'b1;

    initial begin : model
        logic do_push;
        exp_t e;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                m_fifo.delete();
                exp_q.delete();
                m_last   = '0;
                m_cnt    = 0;
                m_tready = 1'b0;
                m_in_rst = 1'b1;
            end else begin
                m_in_rst = 1'b0;
                do_push  = tvalid && m_tready;
                if (m_cnt == SDIV - 1) begin
                    if (m_fifo.size() > 0) begin
                        m_last = m_fifo.pop_front();
                        e.urun = 1'b0;
                    end else begin
                        e.urun = 1'b1;
                    end
                    e.word = m_last;
                    exp_q.push_back(e);
                    m_cnt = 0;
                end else begin
                    m_cnt = m_cnt + 1;
                end
                if (do_push) m_fifo.push_back(tdata);
                m_tready = (m_fifo.size() < DEPTH);
            end
        end
    end

    // SPI decoder / checker, sampling mid-cycle.
    initial begin : monitor
        int            cyc;
        int            last_start;
        int            lowcnt;
        int            nfalls;
        logic          prev_ssn;
        logic          prev_sck;
        logic          in_frame;
        logic          have_cur;
        logic          timing_ok;
        logic [DW-1:0] rx;
        exp_t          cur;
        cyc = 0; last_start = -1; lowcnt = 0; nfalls = 0;
        prev_ssn = 1'b1; prev_sck = 1'b1; in_frame = 1'b0; have_cur = 1'b0;
        timing_ok = 1'b1; rx = '0; cur = '0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (m_in_rst) begin
                checks = checks + 1;
                if (ssn !== 1'b1 || sck !== 1'b1 || mosi !== 1'b0 || urun !== 1'b0 || tready !== 1'b0) begin
                    errors = errors + 1;
                    $display("FAIL reset_state: got ssn=%b sck=%b mosi=%b urun=%b tready=%b, expected 1 1 0 0 0",
                             ssn, sck, mosi, urun, tready);
                end
                in_frame   = 1'b0;
                last_start = -1;
            end else begin
                checks = checks + 1;
                if (tready !== m_tready) begin
                    errors = errors + 1;
                    $display("FAIL tready @%0d: got %b, expected %b", cyc, tready, m_tready);
                end
                if (prev_ssn && !ssn) begin
                    if (last_start >= 0) begin
                        checks = checks + 1;
                        if (cyc - last_start != SDIV) begin
                            errors = errors + 1;
                            $display("FAIL frame_period: got %0d, expected %0d", cyc - last_start, SDIV);
                        end
                    end
                    last_start = cyc;
                    in_frame   = 1'b1;
                    lowcnt     = 0;
                    nfalls     = 0;
                    rx         = '0;
                    timing_ok  = (sck === 1'b1);
                    checks     = checks + 1;
                    if (exp_q.size() == 0) begin
                        have_cur = 1'b0;
                        errors   = errors + 1;
                        $display("FAIL frame_start: got an unpredicted frame @%0d, expected none", cyc);
                    end else begin
                        cur      = exp_q.pop_front();
                        have_cur = 1'b1;
                        if (urun !== cur.urun) begin
                            errors = errors + 1;
                            $display("FAIL underrun_flag: got %b, expected %b", urun, cur.urun);
                        end
                    end
                end else if (urun === 1'b1) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL stray_underrun @%0d: got 1, expected 0", cyc);
                end
                if (in_frame && !ssn) begin
                    if (prev_sck && !sck) begin
                        if (lowcnt != (2 * nfalls + 1) * H) timing_ok = 1'b0;
                        rx     = {rx[DW-2:0], mosi};
                        nfalls = nfalls + 1;
                    end
                    lowcnt = lowcnt + 1;
                end
                if (in_frame && !prev_ssn && ssn) begin
                    in_frame = 1'b0;
                    checks   = checks + 1;
                    if (!have_cur || rx !== cur.word || lowcnt != DW * SCKDIV || nfalls != DW || !timing_ok) begin
                        errors = errors + 1;
                        $display("FAIL frame: got word=%h low=%0d falls=%0d timing_ok=%0d, expected word=%h low=%0d falls=%0d timing_ok=1",
                                 rx, lowcnt, nfalls, timing_ok, cur.word, DW * SCKDIV, DW);
                    end
                end
                if (ssn === 1'b1) begin
                    checks = checks + 1;
                    if (sck !== 1'b1 || mosi !== 1'b0) begin
                        errors = errors + 1;
                        $display("FAIL idle_lines @%0d: got sck=%b mosi=%b, expected 1 0", cyc, sck, mosi);
                    end
                end
            end
            prev_ssn = ssn;
            prev_sck = sck;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout(input string what);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL timeout_%s: got no event within bound, expected event", what);
    endtask

    task automatic do_reset(input int n);
        tvalid = 1'b0;
        rstn   = 1'b0;
        repeat (n) step();
        rstn = 1'b1;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l, input logic hold);
        int n = 0;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = l;
        while (!tready && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) timeout("push");
        step();
        if (!hold) begin
            tvalid = 1'b0;
            tlast  = 1'b0;
        end
    endtask

    task automatic wait_cnt(input int target);
        int n = 0;
        while (m_cnt != target && n < 2 * SDIV) begin
            step();
            n++;
        end
        if (m_cnt != target) timeout("cnt");
    endtask

    logic [DW-1:0] stream[20];

    initial begin : stim
        int   n;
        int   falls;
        logic psck;
        do_reset(4);

        // Single known word after reset
        push(16'hA5C3, 1'b0, 1'b0);
        repeat (2 * SDIV) step();

        // Idle underruns, then one word repeated through later underruns
        do_reset(3);
        repeat (3 * SDIV + 10) step();
        push(16'h1234, 1'b0, 1'b0);
        repeat (3 * SDIV) step();

        // Fill past full with TVALID held
        wait_cnt(1);
        for (int i = 0; i < 9; i++) push(16'h1000 + 16'(i * 16'h0111), 1'b0, 1'b1);
        tvalid = 1'b0;
        repeat (10 * SDIV) step();

        // Push landing on the tick edge with an empty FIFO
        wait_cnt(SDIV - 1);
        tvalid = 1'b1;
        tdata  = 16'hBEEF;
        step();
        tvalid = 1'b0;
        repeat (2 * SDIV) step();

        // Reset on the fifth SCK fall of a frame
        push(16'h5A5A, 1'b0, 1'b0);
        n = 0;
        while (ssn && n < 3 * SDIV) begin step(); n++; end
        if (ssn) timeout("ssn");
        falls = 0; psck = sck; n = 0;
        while (falls < 5 && n < 3 * SDIV) begin
            step();
            if (psck && !sck) falls++;
            psck = sck;
            n++;
        end
        if (falls < 5) timeout("falls");
        do_reset(3);
        repeat (2 * SDIV) step();

        // Same random stream with random TLAST, then without TLAST
        for (int i = 0; i < 20; i++) stream[i] = 16'($urandom);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 20; i++) begin
                push(stream[i], (pass == 0) ? 1'($urandom) : 1'b0, 1'b0);
                repeat ($urandom_range(0, 30)) step();
            end
            n = 0;
            while (m_fifo.size() != 0 && n < 20 * SDIV) begin step(); n++; end
            if (m_fifo.size() != 0) timeout("drain");
            repeat (2 * SDIV) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
